// File: rtl/vecnorm_drain.sv
// vecnorm_drain: credit-gated issue and FWFT result buffer
// for the fixed-latency vecnorm pipe.
module vecnorm_drain #(
  parameter int WIDTH = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic                       issue,
  input  logic                       pipe_valid,
  input  logic [WIDTH-1:0]           pipe_data,
  output logic                       dn_valid,
  output logic [WIDTH-1:0]           dn_data,
  input  logic                       dn_ready,
  output logic [$clog2(DEPTH+1)-1:0] in_flight,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (LAT < 1) begin : g_bad_lat
    $error("vecnorm_drain: LAT must be >= 1");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("vecnorm_drain: DEPTH must be a power of two >= 2");
  end

  logic [CW-1:0]    credits;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic full;
  logic deq;
  logic wr;
  logic ovf;
  logic unf;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign dn_valid = (cnt != '0);
  assign deq      = dn_valid & dn_ready;
  assign wr       = pipe_valid & (~full | deq);
  assign ovf      = pipe_valid & full & ~deq;
  assign unf      = pipe_valid & (in_flight == '0);

  assign up_ready = reset_l & (credits != '0);
  assign issue    = up_valid & up_ready;
  assign dn_data  = dn_valid ? mem[rptr[AW-1:0]] : '0;

  // credit pool: spent on issue, returned when a result leaves
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({issue, deq})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // issued-but-not-returned count; never goes below zero
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      in_flight <= '0;
    end else begin
      in_flight <= in_flight + CW'(issue)
                 - CW'(pipe_valid & ~unf);
    end
  end

  // fifo pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (deq)
        rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(deq);
    end
  end

  // result storage; contents are don't-care once popped
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr[AW-1:0]] <= pipe_data;
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ovf)
        err_overflow <= 1'b1;
      if (unf)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vecnorm_drain.sv
// tb_vecnorm_drain: queue-based model check of vecnorm_drain
// plus directed literal expectations.
module tb_vecnorm_drain;

  localparam int LAT = 4;
  localparam int DEP = 8;

  logic        clk;
  logic        reset_l;
  logic        up_valid;
  logic        up_ready;
  logic        issue;
  logic        pipe_valid;
  logic [31:0] pipe_data;
  logic        dn_valid;
  logic [31:0] dn_data;
  logic        dn_ready;
  logic [3:0]  in_flight;
  logic        err_overflow;
  logic        err_underflow;

  logic        s_rst_l;
  logic        s_up;
  logic        s_up_ready;
  logic        s_issue;
  logic        s_pv;
  logic [31:0] s_pd;
  logic        s_dn_valid;
  logic [31:0] s_dn_data;
  logic        s_dn_ready;
  logic [1:0]  s_in_flight;
  logic        s_err_o;
  logic        s_err_u;

  vecnorm_drain #(.WIDTH(32), .LAT(LAT), .DEPTH(DEP)) u_dut (
    .clk(clk), .reset_l(reset_l),
    .up_valid(up_valid), .up_ready(up_ready), .issue(issue),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready),
    .in_flight(in_flight),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  vecnorm_drain #(.WIDTH(32), .LAT(LAT), .DEPTH(2)) u_small (
    .clk(clk), .reset_l(s_rst_l),
    .up_valid(s_up), .up_ready(s_up_ready), .issue(s_issue),
    .pipe_valid(s_pv), .pipe_data(s_pd),
    .dn_valid(s_dn_valid), .dn_data(s_dn_data), .dn_ready(s_dn_ready),
    .in_flight(s_in_flight),
    .err_overflow(s_err_o), .err_underflow(s_err_u)
  );

  int nvec = 0;
  int nmis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // external fixed-latency pipe for the main dut
  logic        inj_v;
  logic [31:0] inj_d;
  logic [LAT-1:0] pv;
  logic [31:0] pd [LAT];
  int          id;

  assign pipe_valid = pv[LAT-1] | inj_v;
  assign pipe_data  = inj_v ? inj_d : pd[LAT-1];

  always @(posedge clk) begin
    if (!reset_l) begin
      pv <= '0;
      id <= 0;
    end else begin
      pv    <= {pv[LAT-2:0], issue};
      pd[0] <= 32'h1000 + id;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      if (issue) id <= id + 1;
    end
  end

  // pipe for the small dut
  logic [LAT-1:0] spv;
  logic [31:0] spd [LAT];
  int          s_id;

  assign s_pv = spv[LAT-1];
  assign s_pd = spd[LAT-1];

  always @(posedge clk) begin
    if (!s_rst_l) begin
      spv  <= '0;
      s_id <= 0;
    end else begin
      spv    <= {spv[LAT-2:0], s_issue};
      spd[0] <= 32'h2000 + s_id;
      for (int i = 1; i < LAT; i++) spd[i] <= spd[i-1];
      if (s_issue) s_id <= s_id + 1;
    end
  end

  // behavioural model: credit pool, outstanding count, result queue
  int          m_cred = DEP;
  int          m_inf  = 0;
  bit          m_eo   = 0;
  bit          m_eu   = 0;
  bit          m_iss;
  bit          m_dq;
  logic [31:0] mq [$];

  always @(posedge clk) begin
    if (!reset_l) begin
      m_cred = DEP;
      m_inf  = 0;
      m_eo   = 0;
      m_eu   = 0;
      mq.delete();
    end else begin
      m_iss = up_valid && (m_cred > 0);
      m_dq  = (mq.size() > 0) && dn_ready;
      if (m_dq) begin
        void'(mq.pop_front());
        m_cred++;
      end
      if (pipe_valid) begin
        if (m_inf == 0) m_eu = 1;
        else m_inf--;
        if (mq.size() < DEP) mq.push_back(pipe_data);
        else m_eo = 1;
      end
      if (m_iss) begin
        m_cred--;
        m_inf++;
      end
    end
  end

  // every-cycle compare against the model
  bit chk_en = 0;
  bit e_rdy;

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      e_rdy = reset_l && (m_cred > 0);
      chk("up_ready", up_ready, e_rdy);
      chk("issue", issue, e_rdy && up_valid);
      chk("dn_valid", dn_valid, mq.size() != 0);
      if (mq.size() != 0) chk("dn_data", dn_data, mq[0]);
      chk("in_flight", in_flight, m_inf);
      chk("err_overflow", err_overflow, m_eo);
      chk("err_underflow", err_underflow, m_eu);
    end
  end

  // event recorder for latency and last popped value
  int          cyc = 0;
  int          fi  = -1;
  int          fd  = -1;
  logic [31:0] lastdq = '0;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (issue && fi < 0) fi = cyc;
    if (dn_valid && fd < 0) fd = cyc;
    if (dn_valid && dn_ready) lastdq = dn_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n;
  int s_n;
  int s_exp;

  initial begin
    reset_l    = 0;
    up_valid   = 0;
    dn_ready   = 0;
    inj_v      = 0;
    inj_d      = '0;
    s_rst_l    = 0;
    s_up       = 0;
    s_dn_ready = 1;
    s_n        = 0;
    s_exp      = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en   = 1;
    up_valid = 1;
    #1;
    chk("rst_up_ready", up_ready, 0);
    chk("rst_issue", issue, 0);
    chk("rst_dn_valid", dn_valid, 0);
    @(negedge clk);

    // steady stream
    reset_l  = 1;
    dn_ready = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("steady_in_flight", in_flight, 4);
    chk("first_latency", fd - fi, 5);
    @(negedge clk);

    // drain, then backpressure
    up_valid = 0;
    repeat (10) @(negedge clk);
    dn_ready = 0;
    up_valid = 1;
    n = 0;
    repeat (16) begin
      #1;
      if (issue) n++;
      @(negedge clk);
    end
    #1;
    chk("bp_issues", n, 8);
    chk("bp_up_ready", up_ready, 0);
    chk("bp_dn_valid", dn_valid, 1);
    chk("bp_in_flight", in_flight, 0);
    chk("bp_no_ovf", err_overflow, 0);
    @(negedge clk);

    // resume: one issue per dequeue, one cycle later
    dn_ready = 1;
    #1;
    chk("resume_r0_issue", issue, 0);
    @(negedge clk);
    #1;
    chk("resume_r1_issue", issue, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("credit_hold", up_ready, 1);
    @(negedge clk);

    // refill to full
    dn_ready = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("full_dn_valid", dn_valid, 1);
    chk("full_up_ready", up_ready, 0);
    chk("full_in_flight", in_flight, 0);
    @(negedge clk);

    // full fifo: write and dequeue together
    up_valid = 0;
    inj_v    = 1;
    inj_d    = 32'hDEAD_BEEF;
    dn_ready = 1;
    @(negedge clk);
    inj_v    = 0;
    dn_ready = 0;
    #1;
    chk("simul_no_ovf", err_overflow, 0);
    chk("simul_underflow", err_underflow, 1);
    chk("simul_dn_valid", dn_valid, 1);
    @(negedge clk);

    // illegal overflow
    inj_v = 1;
    inj_d = 32'hBAD0_0BAD;
    @(negedge clk);
    inj_v = 0;
    #1;
    chk("ovf_set", err_overflow, 1);
    @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    chk("ovf_sticky", err_overflow, 1);
    @(negedge clk);

    // drain: dropped word must not appear
    dn_ready = 1;
    repeat (12) @(negedge clk);
    #1;
    chk("last_dq", lastdq, 32'hDEAD_BEEF);
    chk("drained", dn_valid, 0);
    @(negedge clk);

    // reset mid-operation
    dn_ready = 0;
    up_valid = 1;
    repeat (7) @(negedge clk);
    #1;
    chk("pre_rst_ovf", err_overflow, 1);
    chk("pre_rst_dn_valid", dn_valid, 1);
    @(negedge clk);
    reset_l  = 0;
    up_valid = 0;
    @(negedge clk);
    reset_l = 1;
    #1;
    chk("post_rst_dn_valid", dn_valid, 0);
    chk("post_rst_in_flight", in_flight, 0);
    chk("post_rst_up_ready", up_ready, 1);
    chk("post_rst_ovf", err_overflow, 0);
    chk("post_rst_unf", err_underflow, 0);
    @(negedge clk);
    repeat (7) @(negedge clk);
    #1;
    chk("no_stale_unf", err_underflow, 0);
    chk("no_stale_dn_valid", dn_valid, 0);
    @(negedge clk);

    // small depth throttling
    s_rst_l = 1;
    s_up    = 1;
    repeat (30) begin
      #1;
      if (s_issue) s_n++;
      if (s_dn_valid) begin
        chk("small_order", s_dn_data, 32'h2000 + s_exp);
        s_exp++;
      end
      @(negedge clk);
    end
    #1;
    chk("small_issues", s_n, 10);
    chk("small_results", s_exp, 9);
    chk("small_no_ovf", s_err_o, 0);
    chk("small_no_unf", s_err_u, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
